// File: rtl/ram_param.sv
// Parametrised single-port RAM with byte enables, valid/ready request port,
// 1- or 2-cycle read latency and a built-in clear engine that fills the array with INIT_VAL.
module ram_param #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 12,
  parameter int                READ_LAT = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     data_in,
  input  logic [DATA_W/8-1:0]   be,
  input  logic                  clr_start,
  output logic                  ready,
  output logic                  busy,
  output logic                  rvalid,
  output logic [DATA_W-1:0]     data_out
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {ST_CLEAR, ST_IDLE} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   dout_q, dout_d;

  logic                rd_acc;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic [NB-1:0]       wr_mask;

  logic [DATA_W-1:0]   mem [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_CLEAR;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      dout_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      dout_q   <= dout_d;
    end
  end

  // The counter wraps to zero on its own at the last word, so IDLE always starts from 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        if (&cnt_q) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (clr_start) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_comb begin
    ready   = (state_q == ST_IDLE);
    busy    = (state_q == ST_CLEAR);
    rd_acc  = req && ready && !we;
    wr_en   = 1'b0;
    wr_addr = addr;
    wr_data = data_in;
    wr_mask = be;
    if (state_q == ST_CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = cnt_q;
      wr_data = INIT_VAL;
      wr_mask = '1;
    end else if (req && we) begin
      wr_en   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_mask[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Reads sample the array before the edge's write lands; an extra stage is added for READ_LAT=2.
  generate
    if (READ_LAT == 2) begin : g_lat2
      logic              s1_valid_q, s1_valid_d;
      logic [DATA_W-1:0] s1_data_q, s1_data_d;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          s1_valid_q <= 1'b0;
          s1_data_q  <= '0;
        end else begin
          s1_valid_q <= s1_valid_d;
          s1_data_q  <= s1_data_d;
        end
      end

      always_comb begin
        s1_valid_d = rd_acc;
        s1_data_d  = rd_acc ? mem[addr] : s1_data_q;
        rvalid_d   = s1_valid_q;
        dout_d     = s1_valid_q ? s1_data_q : dout_q;
      end
    end else begin : g_lat1
      always_comb begin
        rvalid_d = rd_acc;
        dout_d   = rd_acc ? mem[addr] : dout_q;
      end
    end
  endgenerate

  assign rvalid   = rvalid_q;
  assign data_out = dout_q;

endmodule

// File: tb/tb_ram_param.sv
// Bench for ram_param: one READ_LAT=1 and one READ_LAT=2 instance share stimulus;
// per-instance scoreboards hold expected read data and the cycle its rvalid is due.
module tb_ram_param;

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        req;
  logic        we;
  logic [11:0] addr;
  logic [15:0] data_in;
  logic [1:0]  be;
  logic        clr_start;

  logic        ready1, busy1, rvalid1;
  logic [15:0] data_out1;
  logic        ready2, busy2, rvalid2;
  logic [15:0] data_out2;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t q1[$];
  exp_t q2[$];

  ram_param #(.DATA_W(16), .ADDR_W(12), .READ_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr),
    .data_in(data_in), .be(be), .clr_start(clr_start),
    .ready(ready1), .busy(busy1), .rvalid(rvalid1), .data_out(data_out1)
  );

  ram_param #(.DATA_W(16), .ADDR_W(12), .READ_LAT(2)) dut2 (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr),
    .data_in(data_in), .be(be), .clr_start(clr_start),
    .ready(ready2), .busy(busy2), .rvalid(rvalid2), .data_out(data_out2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (rvalid1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL lat1_unexpected_rvalid cycle=%0d data_out=%h", cyc, data_out1);
      end else begin
        e = q1.pop_front();
        if (e.due !== cyc || data_out1 !== e.data) begin
          errors++;
          $display("FAIL lat1_read got data=%h cycle=%0d expected data=%h cycle=%0d",
                   data_out1, cyc, e.data, e.due);
        end
      end
    end else if (q1.size() > 0 && q1[0].due <= cyc) begin
      checks++;
      errors++;
      $display("FAIL lat1_missing_rvalid cycle=%0d expected data=%h due=%0d", cyc, q1[0].data, q1[0].due);
      void'(q1.pop_front());
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rvalid2) begin
      checks++;
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL lat2_unexpected_rvalid cycle=%0d data_out=%h", cyc, data_out2);
      end else begin
        e = q2.pop_front();
        if (e.due !== cyc || data_out2 !== e.data) begin
          errors++;
          $display("FAIL lat2_read got data=%h cycle=%0d expected data=%h cycle=%0d",
                   data_out2, cyc, e.data, e.due);
        end
      end
    end else if (q2.size() > 0 && q2[0].due <= cyc) begin
      checks++;
      errors++;
      $display("FAIL lat2_missing_rvalid cycle=%0d expected data=%h due=%0d", cyc, q2[0].data, q2[0].due);
      void'(q2.pop_front());
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_req(input logic [11:0] a, input logic [15:0] d, input logic [1:0] b);
    req = 1'b1; we = 1'b1; addr = a; data_in = d; be = b;
    tick();
    req = 1'b0; we = 1'b0;
  endtask

  task automatic read_req(input logic [11:0] a, input logic [15:0] exp_data);
    exp_t e;
    req = 1'b1; we = 1'b0; addr = a;
    e.data = exp_data; e.due = cyc + 1; q1.push_back(e);
    e.due = cyc + 2; q2.push_back(e);
    tick();
    req = 1'b0;
  endtask

  task automatic drain;
    int n = 0;
    while ((q1.size() != 0 || q2.size() != 0) && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (q1.size() != 0 || q2.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending lat1=%0d lat2=%0d required 0", q1.size(), q2.size());
      q1.delete();
      q2.delete();
    end
    tick();
  endtask

  task automatic count_busy(input string name);
    int n = 0;
    while (busy1 && n < 5000) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 4096 || busy2 !== 1'b0 || ready1 !== 1'b1 || ready2 !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_cycles=%0d busy2=%b ready=%b%b required 4096 0 11",
               name, n, busy2, ready1, ready2);
    end
  endtask

  task automatic test_reset;
    repeat (3) tick();
    checks++;
    if ({ready1, ready2, busy1, busy2, rvalid1, rvalid2} !== 6'b001100 ||
        data_out1 !== 16'h0 || data_out2 !== 16'h0) begin
      errors++;
      $display("FAIL reset_state ready=%b%b busy=%b%b rvalid=%b%b dout=%h/%h required 00 11 00 0000",
               ready1, ready2, busy1, busy2, rvalid1, rvalid2, data_out1, data_out2);
    end
    reset = 1'b1;
    count_busy("powerup_clear");
    read_req(12'h0FF, 16'h0000);
    drain();
  endtask

  task automatic test_write_read;
    write_req(12'h000, 16'hAAAA, 2'b11);
    write_req(12'h001, 16'hF0F0, 2'b11);
    write_req(12'h0FF, 16'h5555, 2'b11);
    read_req(12'h000, 16'hAAAA);
    read_req(12'h001, 16'hF0F0);
    read_req(12'h0FF, 16'h5555);
    drain();
  endtask

  task automatic test_byte_enable;
    write_req(12'h123, 16'hABCD, 2'b11);
    write_req(12'h123, 16'h00EF, 2'b01);
    read_req(12'h123, 16'hABEF);
    write_req(12'h123, 16'h1234, 2'b00);
    read_req(12'h123, 16'hABEF);
    write_req(12'h124, 16'h9876, 2'b10);
    read_req(12'h124, 16'h9800);
    drain();
  endtask

  task automatic test_read_after_write;
    write_req(12'h010, 16'h1234, 2'b11);
    read_req(12'h010, 16'h1234);
    drain();
    repeat (3) tick();
    checks++;
    if (rvalid1 !== 1'b0 || rvalid2 !== 1'b0 || data_out1 !== 16'h1234 || data_out2 !== 16'h1234) begin
      errors++;
      $display("FAIL data_out_hold rvalid=%b%b dout=%h/%h required 00 1234/1234",
               rvalid1, rvalid2, data_out1, data_out2);
    end
  endtask

  task automatic test_reset_midread;
    exp_t e;
    read_req(12'h123, 16'h0000);
    void'(q1.pop_back());
    void'(q2.pop_back());
    e.data = 16'hABEF; e.due = cyc; q1.push_back(e);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (rvalid2 !== 1'b0 || data_out2 !== 16'h0 || data_out1 !== 16'h0 || busy2 !== 1'b1 || ready2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_midread rvalid2=%b dout=%h/%h busy2=%b ready2=%b required 0 0000/0000 1 0",
               rvalid2, data_out1, data_out2, busy2, ready2);
    end
    tick();
    tick();
    checks++;
    if (rvalid2 !== 1'b0 || data_out2 !== 16'h0) begin
      errors++;
      $display("FAIL reset_cancel rvalid2=%b data_out2=%h required 0 0000", rvalid2, data_out2);
    end
    reset = 1'b1;
    count_busy("reset_restart_clear");
    read_req(12'h123, 16'h0000);
    drain();
  endtask

  task automatic test_clear;
    int n = 0;
    write_req(12'h001, 16'h1111, 2'b11);
    read_req(12'h001, 16'h1111);
    drain();
    req = 1'b1; we = 1'b1; addr = 12'h005; data_in = 16'hBEEF; be = 2'b11; clr_start = 1'b1;
    tick();
    req = 1'b0; we = 1'b0; clr_start = 1'b0;
    checks++;
    if (busy1 !== 1'b1 || busy2 !== 1'b1 || ready1 !== 1'b0 || ready2 !== 1'b0) begin
      errors++;
      $display("FAIL clr_start_entry busy=%b%b ready=%b%b required 11 00", busy1, busy2, ready1, ready2);
    end
    while (busy1 && n < 5000) begin
      if (n == 10 || n == 11) begin
        req = 1'b1; we = (n == 11); addr = 12'h001; data_in = 16'h7777; clr_start = (n == 11);
      end
      tick();
      req = 1'b0; we = 1'b0; clr_start = 1'b0;
      n++;
    end
    checks++;
    if (n !== 4096 || busy2 !== 1'b0 || ready1 !== 1'b1) begin
      errors++;
      $display("FAIL clr_busy_cycles got %0d busy2=%b ready1=%b required 4096 0 1", n, busy2, ready1);
    end
    read_req(12'h005, 16'h0000);
    read_req(12'h001, 16'h0000);
    read_req(12'h0FF, 16'h0000);
    drain();
  endtask

  initial begin
    reset = 1'b0; req = 1'b0; we = 1'b0; addr = '0; data_in = '0; be = '0; clr_start = 1'b0;
    test_reset();
    test_write_read();
    test_byte_enable();
    test_read_after_write();
    test_reset_midread();
    test_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
